// File: rtl/itch_pkg.sv
// Shared ITCH types: message-type bytes, order/trade enums, word-layout bit offsets
// and the decoded record carried through the parser's buffer.
package itch_pkg;

  typedef enum logic [1:0] {
    ORD_ADD     = 2'd0,
    ORD_CANCEL  = 2'd1,
    ORD_EXECUTE = 2'd2
  } order_t;

  typedef enum logic {
    TRADE_BUY  = 1'b0,
    TRADE_SELL = 1'b1
  } trade_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } out_state_t;

  localparam logic [7:0] MSG_ADD     = 8'h41;
  localparam logic [7:0] MSG_CANCEL  = 8'h44;
  localparam logic [7:0] MSG_EXECUTE = 8'h45;
  localparam logic [7:0] SIDE_SELL   = 8'h53;

  // Flat message layout (bit offsets), word 0 = bits 31:0. Common header first,
  // then per-type body starting at bit 152.
  localparam int MSG_BITS      = 288;
  localparam int OFF_TYPE      = 0;
  localparam int OFF_LOCATE    = 8;
  localparam int OFF_TRACK     = 24;
  localparam int OFF_TIME      = 40;
  localparam int OFF_OID       = 88;
  localparam int OFF_ADD_SIDE  = 152;
  localparam int OFF_ADD_QTY   = 160;
  localparam int OFF_ADD_STOCK = 192;
  localparam int OFF_ADD_PRICE = 256;
  localparam int OFF_CAN_STOCK = 152;
  localparam int OFF_EXE_QTY   = 152;
  localparam int OFF_EXE_STOCK = 184;

  localparam int SYM_IDX_W = 8;

  typedef struct packed {
    order_t                order_type;
    trade_t                trade_type;
    logic [SYM_IDX_W-1:0]  sym;
    logic [63:0]           order_id;
    logic [31:0]           price;
    logic [31:0]           quantity;
    logic [47:0]           curr_time;
    logic [15:0]           locate;
    logic [15:0]           tracking;
  } record_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; pushes while full and
// pops while empty are ignored. Pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/itch_msg_parser.sv
// Decodes ITCH ADD/CANCEL/EXECUTE messages, buffers valid records and issues them
// to the order book one at a time with a two-cycle gap, counting discarded messages.
module itch_msg_parser
  import itch_pkg::*;
#(
  parameter int REG_WIDTH   = 32,
  parameter int NUM_REGS    = 9,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_SYMBOLS = 4,
  parameter int SYM_W       = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1,
  parameter logic [NUM_SYMBOLS*64-1:0] SYMBOL_TABLE =
    {"AAPL    ", "AMZN    ", "GOOGL   ", "MSFT    "}
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_data_valid,
  output logic                                 o_ready,
  input  logic [NUM_REGS-1:0][REG_WIDTH-1:0]   i_regs,
  input  logic                                 i_book_is_busy,
  output logic                                 o_valid,
  output logic [1:0]                           o_order_type,
  output logic                                 o_trade_type,
  output logic [SYM_W-1:0]                     o_stock_symbol,
  output logic [63:0]                          o_order_id,
  output logic [31:0]                          o_price,
  output logic [31:0]                          o_quantity,
  output logic [47:0]                          o_curr_time,
  output logic [15:0]                          o_locate_code,
  output logic [15:0]                          o_tracking_number,
  output logic [15:0]                          o_drop_count
);

  localparam int FLAT_W = NUM_REGS * REG_WIDTH;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [FLAT_W-1:0]   flat;
  logic [MSG_BITS-1:0] msg;
  logic [63:0]         stock;
  logic                type_ok, sym_hit, accept, push, pop;
  record_t             rec_d, fifo_rd, out_q;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [15:0]         drop_cnt_d, drop_cnt_q;
  out_state_t          state_q;
  logic                valid_q;

  assign flat = i_regs;
  if (FLAT_W >= MSG_BITS) begin : g_trunc
    assign msg = flat[MSG_BITS-1:0];
  end else begin : g_pad
    assign msg = {{(MSG_BITS-FLAT_W){1'b0}}, flat};
  end

  always_comb begin
    rec_d           = '0;
    type_ok         = 1'b1;
    sym_hit         = 1'b0;
    stock           = msg[OFF_ADD_STOCK +: 64];
    rec_d.order_id  = msg[OFF_OID +: 64];
    rec_d.curr_time = msg[OFF_TIME +: 48];
    rec_d.locate    = msg[OFF_LOCATE +: 16];
    rec_d.tracking  = msg[OFF_TRACK +: 16];
    case (msg[OFF_TYPE +: 8])
      MSG_ADD: begin
        rec_d.order_type = ORD_ADD;
        rec_d.trade_type = (msg[OFF_ADD_SIDE +: 8] == SIDE_SELL) ? TRADE_SELL : TRADE_BUY;
        rec_d.quantity   = msg[OFF_ADD_QTY +: 32];
        rec_d.price      = msg[OFF_ADD_PRICE +: 32];
      end
      MSG_CANCEL: begin
        rec_d.order_type = ORD_CANCEL;
        stock            = msg[OFF_CAN_STOCK +: 64];
      end
      MSG_EXECUTE: begin
        rec_d.order_type = ORD_EXECUTE;
        rec_d.quantity   = msg[OFF_EXE_QTY +: 32];
        stock            = msg[OFF_EXE_STOCK +: 64];
      end
      default: type_ok = 1'b0;
    endcase
    // Descending scan so the lowest matching table index wins.
    for (int i = NUM_SYMBOLS - 1; i >= 0; i--) begin
      if (stock == SYMBOL_TABLE[(NUM_SYMBOLS-1-i)*64 +: 64]) begin
        sym_hit   = 1'b1;
        rec_d.sym = SYM_IDX_W'(i);
      end
    end
  end

  assign o_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept  = i_data_valid && !fifo_full;
  assign push    = accept && type_ok && sym_hit;
  assign pop     = (state_q == S_IDLE) && !fifo_empty && !i_book_is_busy;

  sync_fifo #(
    .WIDTH ($bits(record_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_wdata (rec_d),
    .i_pop   (pop),
    .o_rdata (fifo_rd),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !(type_ok && sym_hit) && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_ISSUE;
            valid_q <= 1'b1;
            out_q   <= fifo_rd;
          end
        end
        S_ISSUE: begin
          state_q <= S_GAP;
          valid_q <= 1'b0;
        end
        S_GAP:   state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid           = valid_q;
  assign o_order_type      = out_q.order_type;
  assign o_trade_type      = out_q.trade_type;
  assign o_stock_symbol    = SYM_W'(out_q.sym);
  assign o_order_id        = out_q.order_id;
  assign o_price           = out_q.price;
  assign o_quantity        = out_q.quantity;
  assign o_curr_time       = out_q.curr_time;
  assign o_locate_code     = out_q.locate;
  assign o_tracking_number = out_q.tracking;
  assign o_drop_count      = drop_cnt_q;

endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_itch_msg_parser;

  logic              i_clk = 1'b0;
  logic              i_reset, i_data_valid, i_book_is_busy;
  logic [8:0][31:0]  i_regs;
  logic              o_ready, o_valid, o_trade_type;
  logic [1:0]        o_order_type, o_stock_symbol;
  logic [63:0]       o_order_id;
  logic [31:0]       o_price, o_quantity;
  logic [47:0]       o_curr_time;
  logic [15:0]       o_locate_code, o_tracking_number, o_drop_count;

  itch_msg_parser dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data_valid(i_data_valid), .o_ready(o_ready),
    .i_regs(i_regs), .i_book_is_busy(i_book_is_busy), .o_valid(o_valid),
    .o_order_type(o_order_type), .o_trade_type(o_trade_type), .o_stock_symbol(o_stock_symbol),
    .o_order_id(o_order_id), .o_price(o_price), .o_quantity(o_quantity),
    .o_curr_time(o_curr_time), .o_locate_code(o_locate_code),
    .o_tracking_number(o_tracking_number), .o_drop_count(o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  typ;
    logic [15:0] loc, trk;
    logic [47:0] ts;
    logic [63:0] oid;
    logic        sell;
    logic [31:0] qty, price;
    logic [63:0] stock;
  } msg_t;

  typedef struct packed {
    logic [1:0]  ot;
    logic        tt;
    logic [1:0]  sym;
    logic [63:0] oid;
    logic [31:0] price, qty;
    logic [47:0] ts;
    logic [15:0] loc, trk;
  } exp_t;

  logic [63:0] syms [5] = '{"AAPL    ", "AMZN    ", "GOOGL   ", "MSFT    ", "TSLA    "};

  int checks = 0, errors = 0, cycle = 0;
  logic chk_en = 1'b0;
  msg_t cur_msg;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  function automatic logic [287:0] build(input msg_t m);
    logic [287:0] v = '0;
    v[7:0] = m.typ; v[23:8] = m.loc; v[39:24] = m.trk; v[87:40] = m.ts; v[151:88] = m.oid;
    case (m.typ)
      8'h41: begin
        v[159:152] = m.sell ? 8'h53 : 8'h42;
        v[191:160] = m.qty; v[255:192] = m.stock; v[287:256] = m.price;
      end
      8'h44:   v[215:152] = m.stock;
      8'h45:   begin v[183:152] = m.qty; v[247:184] = m.stock; end
      default: v[255:192] = m.stock;
    endcase
    return v;
  endfunction

  // What the order book should see for a message; returns 0 if it must be dropped.
  function automatic bit expect_of(input msg_t m, output exp_t e);
    int idx = -1;
    e = '0;
    for (int i = 0; i < 4; i++) if (m.stock == syms[i]) idx = i;
    case (m.typ)
      8'h41: begin e.ot = 2'd0; e.tt = m.sell; e.price = m.price; e.qty = m.qty; end
      8'h44: e.ot = 2'd1;
      8'h45: begin e.ot = 2'd2; e.qty = m.qty; end
      default: return 1'b0;
    endcase
    if (idx < 0) return 1'b0;
    e.sym = 2'(idx); e.oid = m.oid; e.ts = m.ts; e.loc = m.loc; e.trk = m.trk;
    return 1'b1;
  endfunction

  exp_t mq[$];
  exp_t cur = '0;
  exp_t e_tmp;
  logic exp_vld = 1'b0;
  int   drops_m = 0, since = 3, pre;

  // Reference: a record may issue when buffered, book idle and >=3 edges since the last issue.
  always @(posedge i_clk) begin
    cycle++;
    if (i_reset) begin
      mq.delete(); cur = '0; exp_vld = 1'b0; drops_m = 0; since = 3;
    end else begin
      pre = mq.size();
      if (since < 100) since++;
      exp_vld = 1'b0;
      if (pre > 0 && !i_book_is_busy && since >= 3) begin
        cur = mq.pop_front(); exp_vld = 1'b1; since = 0;
      end
      if (i_data_valid && pre < 4) begin
        if (expect_of(cur_msg, e_tmp)) mq.push_back(e_tmp);
        else if (drops_m < 65535) drops_m++;
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("valid", o_valid, exp_vld);
      chk("ready", o_ready, mq.size() < 4);
      chk("drop_count", o_drop_count, drops_m);
      chk("record", {o_order_type, o_trade_type, o_stock_symbol, o_order_id, o_price,
                     o_quantity, o_curr_time, o_locate_code, o_tracking_number}, cur);
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic drive(input msg_t m);
    cur_msg = m; i_regs = build(m); i_data_valid = 1'b1;
  endtask

  task automatic wait_valid(input string nm, output int cyc);
    cyc = -1;
    for (int k = 0; k < 30; k++) begin
      if (o_valid) begin cyc = cycle; return; end
      step();
    end
    errors++;
    $display("FAIL %s: o_valid never rose within 30 cycles", nm);
  endtask

  function automatic msg_t mk(input logic [7:0] t, input logic [63:0] s, input logic [63:0] oid,
                              input logic [31:0] q, input logic [31:0] p, input logic sell);
    msg_t m;
    m.typ = t; m.stock = s; m.oid = oid; m.qty = q; m.price = p; m.sell = sell;
    m.loc = 16'h0011; m.trk = 16'h0022; m.ts = 48'h0000_1234_5678;
    return m;
  endfunction

  function automatic msg_t rnd_msg();
    msg_t m;
    int r = $urandom_range(9);
    m.typ   = (r < 4) ? 8'h41 : (r < 7) ? 8'h44 : (r < 9) ? 8'h45 : 8'h58;
    m.stock = syms[$urandom_range(4)];
    m.sell  = 1'($urandom);
    m.oid   = {$urandom, $urandom};
    m.ts    = {16'($urandom), $urandom};
    m.qty   = $urandom; m.price = $urandom;
    m.loc   = 16'($urandom); m.trk = 16'($urandom);
    return m;
  endfunction

  initial begin
    int c1, c2, acc;
    logic saw;
    i_reset = 1'b1; i_data_valid = 1'b0; i_book_is_busy = 1'b0; i_regs = '0;
    cur_msg = mk(8'h00, '0, '0, '0, '0, 1'b0);
    step(); chk_en = 1'b1; step();
    i_reset = 1'b0;
    chk("reset_ready", o_ready, 1'b1);
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_drops", o_drop_count, 16'd0);
    chk("reset_oid", o_order_id, 64'd0);

    // Single ADD: two-edge latency, full 64-bit ID
    drive(mk(8'h41, "AAPL    ", 64'h0123456789ABCDEF, 32'd100, 32'd2500, 1'b1));
    step(); i_data_valid = 1'b0;
    chk("add_lat_e", o_valid, 1'b0);
    step();
    chk("add_valid", o_valid, 1'b1);
    chk("add_sym", o_stock_symbol, 2'd0);
    chk("add_type", o_order_type, 2'd0);
    chk("add_trade", o_trade_type, 1'b1);
    chk("add_oid", o_order_id, 64'h0123456789ABCDEF);
    chk("add_qty", o_quantity, 32'd100);
    chk("add_price", o_price, 32'd2500);
    step();
    chk("add_one_shot", o_valid, 1'b0);
    repeat (3) step();

    // CANCEL then EXECUTE back-to-back
    drive(mk(8'h44, "MSFT    ", 64'hD1, 32'd7, 32'd9, 1'b1)); step();
    drive(mk(8'h45, "GOOGL   ", 64'hE2, 32'd50, 32'd9, 1'b1)); step();
    i_data_valid = 1'b0;
    wait_valid("cancel_rec", c1);
    chk("cancel_sym", o_stock_symbol, 2'd3);
    chk("cancel_type", o_order_type, 2'd1);
    chk("cancel_zeroes", {o_price, o_quantity, o_trade_type}, 65'd0);
    step();
    wait_valid("exec_rec", c2);
    chk("exec_sym", o_stock_symbol, 2'd2);
    chk("exec_type", o_order_type, 2'd2);
    chk("exec_qty", o_quantity, 32'd50);
    chk("exec_spacing", c2 - c1, 3);
    repeat (3) step();

    // Unknown type and unknown symbol are dropped
    drive(mk(8'h58, "AAPL    ", 64'h1, 32'd1, 32'd1, 1'b0)); step();
    drive(mk(8'h41, "TSLA    ", 64'h2, 32'd1, 32'd1, 1'b0)); step();
    i_data_valid = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin saw |= o_valid; step(); end
    chk("drop_no_valid", saw, 1'b0);
    chk("drop_count2", o_drop_count, 16'd2);

    // Busy book: buffer fills at 4, then drains in order
    i_book_is_busy = 1'b1; acc = 0;
    for (int k = 0; k < 5; k++) begin
      drive(mk(8'h41, "AMZN    ", 64'h100 + 64'(k), 32'd1, 32'd1, 1'b0));
      if (o_ready) acc++;
      step();
    end
    i_data_valid = 1'b0;
    chk("full_accepted", acc, 4);
    chk("full_ready_low", o_ready, 1'b0);
    step();
    chk("full_ready_hold", o_ready, 1'b0);
    i_book_is_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid("drain_rec", c1);
      chk("drain_order", o_order_id, 64'h100 + 64'(k));
      if (k == 0) chk("drain_ready", o_ready, 1'b1);
      step();
    end
    repeat (3) step();

    // Reset flushes buffered records
    i_book_is_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(mk(8'h41, "MSFT    ", 64'h200 + 64'(k), 32'd1, 32'd1, 1'b0)); step();
    end
    i_data_valid = 1'b0; i_reset = 1'b1; step();
    i_reset = 1'b0; i_book_is_busy = 1'b0;
    chk("flush_ready", o_ready, 1'b1);
    chk("flush_drops", o_drop_count, 16'd0);
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin saw |= o_valid; step(); end
    chk("flush_no_valid", saw, 1'b0);

    // Random traffic, busy and occasional reset
    for (int k = 0; k < 600; k++) begin
      drive(rnd_msg());
      i_data_valid   = ($urandom_range(2) != 0);
      i_book_is_busy = ($urandom_range(3) == 0);
      i_reset        = ($urandom_range(149) == 0);
      step();
    end
    i_data_valid = 1'b0; i_book_is_busy = 1'b0; i_reset = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/itch_msg_parser.md
ITCH_MSG_PARSER -- requirements
Module: itch_msg_parser

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, register word width.
REQ-002 SHALL have parameter NUM_REGS, default 9, words per message.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), decoded-record buffer depth.
REQ-004 SHALL have parameter NUM_SYMBOLS, default 4, symbol table entries; SYM_W = max(1, clog2(NUM_SYMBOLS)).
REQ-005 SHALL have parameter SYMBOL_TABLE, NUM_SYMBOLS x 64 bits, default {"AAPL    ","AMZN    ","GOOGL   ","MSFT    "}; entry i maps to symbol index i.
REQ-006 i_clk  in  1  sole clock; single clock domain.
REQ-007 i_reset  in  1  reset; synchronous, active-high.
REQ-008 i_data_valid  in  1  message present on i_regs.
REQ-009 o_ready  out  1  parser can accept a message.
REQ-010 i_regs  in  NUM_REGS x REG_WIDTH  message words; word 0 holds bits 31:0.
REQ-011 i_book_is_busy  in  1  order book cannot take a record.
REQ-012 o_valid  out  1  one-cycle record strobe.
REQ-013 o_order_type  out  2  ADD=0, CANCEL=1, EXECUTE=2.
REQ-014 o_trade_type  out  1  BUY=0, SELL=1.
REQ-015 o_stock_symbol  out  SYM_W  matched symbol index.
REQ-016 o_order_id  out  64; o_price  out  32; o_quantity  out  32; o_curr_time  out  48.
REQ-017 o_locate_code  out  16; o_tracking_number  out  16.
REQ-018 o_drop_count  out  16  saturating count of discarded messages.

Function
REQ-019 A message SHALL be accepted on a rising edge where i_data_valid && o_ready; o_ready = (FIFO occupancy < FIFO_DEPTH).
REQ-020 Field extraction SHALL follow the team ITCH word layout: type byte 'A'(0x41)=ADD, 'D'(0x44)=CANCEL, 'E'(0x45)=EXECUTE; order ID 64 bits (full width, no truncation); timestamp 48 bits; stock ID position per type.
REQ-021 CANCEL records SHALL carry price=0, quantity=0, trade_type=0; EXECUTE records price=0, trade_type=0.
REQ-022 An accepted message with an unknown type byte or a stock ID matching no SYMBOL_TABLE entry SHALL be discarded (not buffered) and o_drop_count incremented, saturating at 0xFFFF.
REQ-023 Valid accepted messages SHALL be written to the FIFO on the accepting edge.
REQ-024 Output FSM states: IDLE, ISSUE, GAP. IDLE->ISSUE when FIFO non-empty and !i_book_is_busy (pop on that edge, outputs registered); ISSUE->GAP unconditionally; GAP->IDLE unconditionally.
REQ-025 o_valid SHALL be high only in ISSUE, exactly one cycle per record; output fields SHALL hold their value until the next pop.
REQ-026 Minimum latency: message accepted at edge E SHALL produce o_valid high after edge E+1; back-to-back record spacing SHALL be >=3 cycles.
REQ-027 Records SHALL emerge in acceptance order.
REQ-028 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-029 While full, o_ready SHALL be low and i_data_valid ignored (no drop count increment).
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 On i_reset high at an edge: FIFO emptied, FSM IDLE, o_valid=0, o_drop_count=0, all record outputs 0; o_ready high in the following cycle.
REQ-032 Reset mid-operation SHALL flush buffered records; none SHALL be emitted afterwards.

Structure
REQ-033 Package itch_pkg SHALL hold order_t, trade_t, message-type byte constants and the decoded record struct.
REQ-034 Buffer SHALL be a sub-module sync_fifo (parametrised width/depth, push/pop/full/empty/count).

Verification
REQ-035 ADD 'A', stock "AAPL    ", order ID 0x0123456789ABCDEF, qty 100, price 2500, sell -> one o_valid, symbol 0, type 0, trade 1, full 64-bit ID, 2-edge latency.
REQ-036 DELETE 'D' for "MSFT    " then EXECUTE 'E' qty 50 "GOOGL   " back-to-back -> two records in order, symbols 3 then 2, o_valid separated by 3 cycles.
REQ-037 Type 0x58 and ADD with stock "TSLA    " -> no o_valid, o_drop_count=2.
REQ-038 i_book_is_busy held high, 5 valid ADDs offered each cycle -> 4 accepted, o_ready low thereafter; busy released -> 4 records in order, o_ready high after first pop.
REQ-039 Reset asserted with 3 records buffered -> no o_valid afterwards, o_drop_count=0, o_ready high next cycle.
